// File: rtl/dtack_pkg.sv
// ---------------------------------------------------------------------------
// dtack_pkg
// Shared types for the bus-cycle acknowledge generator:
//   - region_t : decoded target region of the current 68k bus cycle
//   - state_t  : acknowledge FSM states
//   - counter widths for the fixed wait-state and external timeout counters
//   - decode_region : fixed-priority select encoder (ROM > RAM > IACK > IO > EXP)
// ---------------------------------------------------------------------------
package dtack_pkg;

    localparam int WAIT_W = 4;   // fixed wait-state counter width
    localparam int TMO_W  = 8;   // external-acknowledge timeout counter width

    typedef enum logic [2:0] {
        REG_NONE,
        REG_ROM,
        REG_RAM,
        REG_IACK,
        REG_IO,
        REG_EXP
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIX,
        ST_WAIT_EXT,
        ST_ACK,
        ST_ERR
    } state_t;

    // All selects are active low; the first low select in priority order wins.
    function automatic region_t decode_region(
        input logic romsel_n,
        input logic ramsel_n,
        input logic iack_n,
        input logic iosel_n,
        input logic expsel_n
    );
        region_t r;
        r = REG_NONE;
        if (!romsel_n)      r = REG_ROM;
        else if (!ramsel_n) r = REG_RAM;
        else if (!iack_n)   r = REG_IACK;
        else if (!iosel_n)  r = REG_IO;
        else if (!expsel_n) r = REG_EXP;
        return r;
    endfunction

endpackage

// File: rtl/dtack_gen.sv
// ---------------------------------------------------------------------------
// dtack_gen
// Bus-cycle acknowledge generator for a 68k system. For each decoded cycle it
// asserts a registered DTACK drive enable after a per-region number of wait
// states (ROM/RAM), or forwards an external acknowledge (EXP/IO/IACK). A cycle
// whose external acknowledge never arrives ends with a registered bus error.
//
// Ports:
//   CLK        in   CPU clock
//   HWRST      in   asynchronous active-high reset
//   ASn        in   address strobe, active low
//   ROMSELn    in   ROM select, active low
//   RAMSELn    in   onboard RAM select, active low
//   IOSELn     in   IO region select, active low
//   EXPSELn    in   expansion region select, active low
//   IACKn      in   DUART interrupt-acknowledge cycle, active low
//   EXPDTACKn  in   expansion card acknowledge, active low
//   IODTACKn   in   IO / IACK acknowledge, active low
//   DTACK_OE   out  drive enable for DTACKn (top level drives low when set)
//   BERRn      out  bus error, active low
//   BUSY       out  high whenever a cycle is owned
// ---------------------------------------------------------------------------
module dtack_gen
    import dtack_pkg::*;
#(
    parameter int ROM_WAIT = 2,
    parameter int RAM_WAIT = 0,
    parameter int TIMEOUT  = 127
) (
    input  logic CLK,
    input  logic HWRST,
    input  logic ASn,
    input  logic ROMSELn,
    input  logic RAMSELn,
    input  logic IOSELn,
    input  logic EXPSELn,
    input  logic IACKn,
    input  logic EXPDTACKn,
    input  logic IODTACKn,
    output logic DTACK_OE,
    output logic BERRn,
    output logic BUSY
);

    // Counter load values: the wait counter starts at W-1 so that ACK is
    // entered on edge E0+W; the timeout fires when the count reaches TIMEOUT-1.
    localparam logic [WAIT_W-1:0] ROM_LOAD = WAIT_W'(ROM_WAIT - 1);
    localparam logic [WAIT_W-1:0] RAM_LOAD = WAIT_W'(RAM_WAIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    region_t            region_q, region_d;
    logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
    logic [TMO_W-1:0]   tcnt_q, tcnt_d;
    logic               dtack_q, berr_n_q, busy_q;

    region_t            sel_region;
    logic               ext_ack;

    assign sel_region = decode_region(ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn);

    // IACK cycles are acknowledged by the DUART, so they share IODTACKn.
    assign ext_ack = (region_q == REG_EXP) ? ~EXPDTACKn : ~IODTACKn;

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!ASn) begin
                    region_d = sel_region;
                    case (sel_region)
                        REG_ROM: begin
                            if (ROM_WAIT == 0) begin
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_WAIT_FIX;
                                wcnt_d  = ROM_LOAD;
                            end
                        end
                        REG_RAM: begin
                            if (RAM_WAIT == 0) begin
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_WAIT_FIX;
                                wcnt_d  = RAM_LOAD;
                            end
                        end
                        REG_IACK, REG_IO, REG_EXP: begin
                            state_d = ST_WAIT_EXT;
                            tcnt_d  = '0;
                        end
                        // Unmapped access: left to the system watchdog.
                        default: region_d = REG_NONE;
                    endcase
                end
            end

            ST_WAIT_FIX: begin
                if (ASn) begin
                    // Aborted cycle: drop everything, no DTACK.
                    state_d  = ST_IDLE;
                    region_d = REG_NONE;
                    wcnt_d   = '0;
                end else if (wcnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end

            ST_WAIT_EXT: begin
                if (ASn) begin
                    state_d  = ST_IDLE;
                    region_d = REG_NONE;
                    tcnt_d   = '0;
                end else if (ext_ack) begin
                    // Acknowledge beats a timeout landing on the same edge.
                    state_d = ST_ACK;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_ACK, ST_ERR: begin
                if (ASn) begin
                    state_d  = ST_IDLE;
                    region_d = REG_NONE;
                    wcnt_d   = '0;
                    tcnt_d   = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                region_d = REG_NONE;
                wcnt_d   = '0;
                tcnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and have no combinational input paths.
    always_ff @(posedge CLK or posedge HWRST) begin
        if (HWRST) begin
            state_q  <= ST_IDLE;
            region_q <= REG_NONE;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            dtack_q  <= 1'b0;
            berr_n_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            dtack_q  <= (state_d == ST_ACK);
            berr_n_q <= (state_d != ST_ERR);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign DTACK_OE = dtack_q;
    assign BERRn    = berr_n_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_dtack_gen.sv
module tb_dtack_gen;

    // Select bundle order: {ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn}
    localparam logic [4:0] S_NONE = 5'b11111;
    localparam logic [4:0] S_ROM  = 5'b01111;
    localparam logic [4:0] S_RAM  = 5'b10111;
    localparam logic [4:0] S_IACK = 5'b11011;
    localparam logic [4:0] S_IO   = 5'b11101;
    localparam logic [4:0] S_EXP  = 5'b11110;

    // Expected output vector {DTACK_OE, BERRn, BUSY}
    localparam logic [2:0] O_IDLE = 3'b010;
    localparam logic [2:0] O_WAIT = 3'b011;
    localparam logic [2:0] O_ACK  = 3'b111;
    localparam logic [2:0] O_ERR  = 3'b001;

    localparam int TMO = 127;

    logic CLK = 1'b0;
    logic HWRST;
    logic ASn;
    logic ROMSELn, RAMSELn, IOSELn, EXPSELn, IACKn;
    logic EXPDTACKn, IODTACKn;
    logic DTACK_OE, BERRn, BUSY;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 CLK = ~CLK;

    dtack_gen #(.ROM_WAIT(2), .RAM_WAIT(0), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .HWRST     (HWRST),
        .ASn       (ASn),
        .ROMSELn   (ROMSELn),
        .RAMSELn   (RAMSELn),
        .IOSELn    (IOSELn),
        .EXPSELn   (EXPSELn),
        .IACKn     (IACKn),
        .EXPDTACKn (EXPDTACKn),
        .IODTACKn  (IODTACKn),
        .DTACK_OE  (DTACK_OE),
        .BERRn     (BERRn),
        .BUSY      (BUSY)
    );

    task automatic check(input string tag);
        logic [2:0] obs;
        logic [2:0] expv;
        obs = {DTACK_OE, BERRn, BUSY};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed=%b", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed {dtack,berrn,busy}=%b expected=%b", tag, obs, expv);
            end
        end
    endtask

    // Drive one edge's worth of inputs, queue the expectation, then sample
    // just after the edge.
    task automatic cyc(input logic asn, input logic [4:0] sel,
                       input logic expack_n, input logic ioack_n,
                       input logic [2:0] expv, input string tag);
        ASn = asn;
        {ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn} = sel;
        EXPDTACKn = expack_n;
        IODTACKn  = ioack_n;
        exp_q.push_back(expv);
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    initial begin
        HWRST = 1'b1;
        ASn = 1'b1;
        {ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn} = S_NONE;
        EXPDTACKn = 1'b1;
        IODTACKn  = 1'b1;
        #2;
        exp_q.push_back(O_IDLE);
        check("reset_state");
        repeat (2) @(posedge CLK);
        #1;
        HWRST = 1'b0;
        cyc(1, S_NONE, 1, 1, O_IDLE, "idle_after_reset");

        // ROM read, default 2 wait states
        cyc(0, S_ROM, 1, 1, O_WAIT, "rom_e0");
        cyc(0, S_ROM, 1, 1, O_WAIT, "rom_e1");
        cyc(0, S_ROM, 1, 1, O_ACK,  "rom_e2_ack");
        cyc(0, S_ROM, 1, 1, O_ACK,  "rom_ack_hold");
        cyc(1, S_NONE, 1, 1, O_IDLE, "rom_release");

        // Back-to-back RAM cycles, zero wait
        cyc(0, S_RAM, 1, 1, O_ACK,  "ram1_e0_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "ram1_release");
        cyc(0, S_RAM, 1, 1, O_ACK,  "ram2_e0_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "ram2_release");

        // Unmapped access stays idle
        cyc(0, S_NONE, 1, 1, O_IDLE, "unmapped_idle");
        cyc(1, S_NONE, 1, 1, O_IDLE, "unmapped_release");

        // EXP cycle acknowledged at edge E0+5
        cyc(0, S_EXP, 1, 1, O_WAIT, "exp_e0");
        for (int i = 1; i < 5; i++) cyc(0, S_EXP, 1, 1, O_WAIT, "exp_wait");
        cyc(0, S_EXP, 0, 1, O_ACK, "exp_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "exp_release");

        // EXP cycle acknowledged exactly on the timeout edge: ACK wins
        cyc(0, S_EXP, 1, 1, O_WAIT, "exp_tmo_e0");
        for (int i = 1; i < TMO; i++) cyc(0, S_EXP, 1, 1, O_WAIT, "exp_tmo_wait");
        cyc(0, S_EXP, 0, 1, O_ACK, "exp_ack_on_timeout_edge");
        cyc(1, S_NONE, 1, 1, O_IDLE, "exp_tmo_release");

        // IO cycle never acknowledged (EXP ack must not count for IO)
        cyc(0, S_IO, 1, 1, O_WAIT, "io_e0");
        cyc(0, S_IO, 0, 1, O_WAIT, "io_ignores_expack");
        for (int i = 2; i < TMO; i++) cyc(0, S_IO, 1, 1, O_WAIT, "io_wait");
        cyc(0, S_IO, 1, 1, O_ERR, "io_berr");
        cyc(0, S_IO, 1, 1, O_ERR, "io_berr_hold1");
        cyc(0, S_IO, 1, 1, O_ERR, "io_berr_hold2");
        cyc(1, S_NONE, 1, 1, O_IDLE, "io_berr_release");

        // IACK acknowledged through IODTACKn
        cyc(0, S_IACK, 1, 1, O_WAIT, "iack_e0");
        cyc(0, S_IACK, 1, 0, O_ACK,  "iack_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "iack_release");

        // Aborted ROM cycle, then a full ROM cycle
        cyc(0, S_ROM, 1, 1, O_WAIT, "abort_e0");
        cyc(0, S_ROM, 1, 1, O_WAIT, "abort_e1");
        cyc(1, S_NONE, 1, 1, O_IDLE, "abort_no_dtack");
        cyc(0, S_ROM, 1, 1, O_WAIT, "rom2_e0");
        cyc(0, S_ROM, 1, 1, O_WAIT, "rom2_e1");
        cyc(0, S_ROM, 1, 1, O_ACK,  "rom2_full_wait_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "rom2_release");

        // ROM and EXP both selected: ROM timing, EXP ack ignored
        cyc(0, S_ROM & S_EXP, 0, 1, O_WAIT, "romexp_e0");
        cyc(0, S_ROM & S_EXP, 0, 1, O_WAIT, "romexp_e1");
        cyc(0, S_ROM & S_EXP, 0, 1, O_ACK,  "romexp_e2_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "romexp_release");

        // Selects dropped mid-cycle are ignored
        cyc(0, S_ROM,  1, 1, O_WAIT, "selchg_e0");
        cyc(0, S_NONE, 1, 1, O_WAIT, "selchg_e1");
        cyc(0, S_NONE, 1, 1, O_ACK,  "selchg_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "selchg_release");

        // Asynchronous reset in WAIT_EXT
        cyc(0, S_IO, 1, 1, O_WAIT, "rst_ext_e0");
        cyc(0, S_IO, 1, 1, O_WAIT, "rst_ext_e1");
        #2 HWRST = 1'b1;
        #1;
        exp_q.push_back(O_IDLE);
        check("hwrst_in_wait_ext");
        ASn = 1'b1;
        {ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn} = S_NONE;
        #1 HWRST = 1'b0;
        cyc(1, S_NONE, 1, 1, O_IDLE, "rst_ext_after");

        // Asynchronous reset in ACK
        cyc(0, S_RAM, 1, 1, O_ACK, "rst_ack_e0");
        #2 HWRST = 1'b1;
        #1;
        exp_q.push_back(O_IDLE);
        check("hwrst_in_ack");
        ASn = 1'b1;
        {ROMSELn, RAMSELn, IACKn, IOSELn, EXPSELn} = S_NONE;
        #1 HWRST = 1'b0;
        cyc(1, S_NONE, 1, 1, O_IDLE, "rst_ack_after");
        cyc(0, S_RAM, 1, 1, O_ACK, "post_rst_ram_ack");
        cyc(1, S_NONE, 1, 1, O_IDLE, "post_rst_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
